// File: rtl/tap_pkg.sv
// Shared TAP definitions: state encoding, IR width/constants and the TMS next-state function.
// Pure declarations; no latency or backpressure of its own.
package tap_pkg;

  localparam int IR_W = 4;

  localparam logic [3:0] ST_TLR   = 4'hF;
  localparam logic [3:0] ST_RTI   = 4'hC;
  localparam logic [3:0] ST_SELDR = 4'h7;
  localparam logic [3:0] ST_CAPDR = 4'h6;
  localparam logic [3:0] ST_SHDR  = 4'h2;
  localparam logic [3:0] ST_EX1DR = 4'h1;
  localparam logic [3:0] ST_PSDR  = 4'h3;
  localparam logic [3:0] ST_EX2DR = 4'h0;
  localparam logic [3:0] ST_UPDR  = 4'h5;
  localparam logic [3:0] ST_SELIR = 4'h4;
  localparam logic [3:0] ST_CAPIR = 4'hE;
  localparam logic [3:0] ST_SHIR  = 4'hA;
  localparam logic [3:0] ST_EX1IR = 4'h9;
  localparam logic [3:0] ST_PSIR  = 4'hB;
  localparam logic [3:0] ST_EX2IR = 4'h8;
  localparam logic [3:0] ST_UPIR  = 4'hD;

  typedef enum logic [3:0] {
    S_TLR   = ST_TLR,   S_RTI   = ST_RTI,
    S_SELDR = ST_SELDR, S_CAPDR = ST_CAPDR, S_SHDR = ST_SHDR, S_EX1DR = ST_EX1DR,
    S_PSDR  = ST_PSDR,  S_EX2DR = ST_EX2DR, S_UPDR = ST_UPDR,
    S_SELIR = ST_SELIR, S_CAPIR = ST_CAPIR, S_SHIR = ST_SHIR, S_EX1IR = ST_EX1IR,
    S_PSIR  = ST_PSIR,  S_EX2IR = ST_EX2IR, S_UPIR = ST_UPIR
  } tap_state_e;

  localparam logic [IR_W-1:0] IR_IDCODE  = 4'h7;
  localparam logic [IR_W-1:0] IR_BYPASS  = 4'hF;
  localparam logic [IR_W-1:0] IR_RESET   = IR_IDCODE;
  localparam logic [IR_W-1:0] IR_CAPTURE = 4'b0001;

  function automatic tap_state_e tap_next(input tap_state_e s, input logic tms);
    tap_state_e n;
    case (s)
      S_TLR:   n = tms ? S_TLR   : S_RTI;
      S_RTI:   n = tms ? S_SELDR : S_RTI;
      S_SELDR: n = tms ? S_SELIR : S_CAPDR;
      S_CAPDR: n = tms ? S_EX1DR : S_SHDR;
      S_SHDR:  n = tms ? S_EX1DR : S_SHDR;
      S_EX1DR: n = tms ? S_UPDR  : S_PSDR;
      S_PSDR:  n = tms ? S_EX2DR : S_PSDR;
      S_EX2DR: n = tms ? S_UPDR  : S_SHDR;
      S_UPDR:  n = tms ? S_SELDR : S_RTI;
      S_SELIR: n = tms ? S_TLR   : S_CAPIR;
      S_CAPIR: n = tms ? S_EX1IR : S_SHIR;
      S_SHIR:  n = tms ? S_EX1IR : S_SHIR;
      S_EX1IR: n = tms ? S_UPIR  : S_PSIR;
      S_PSIR:  n = tms ? S_EX2IR : S_PSIR;
      S_EX2IR: n = tms ? S_UPIR  : S_SHIR;
      S_UPIR:  n = tms ? S_SELDR : S_RTI;
      default: n = S_TLR;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/tap_controller_if.sv
// JTAG pin/decoder bundle around the TAP controller; master is the controller side.
// Wires only; no latency, no backpressure.
interface tap_controller_if;
  import tap_pkg::*;

  logic            TMS;
  logic            TDI;
  logic            DR_TDO;
  logic            TDO;
  logic            TDO_EN;
  logic [IR_W-1:0] LATCH_JTAG_IR;
  logic            TEST_LOGIC_RESET;
  logic            RUN_TEST_IDLE;
  logic            CAPTURE_DR;
  logic            SHIFT_DR;
  logic            UPDATE_DR;

  modport master (
    input  TMS, TDI, DR_TDO,
    output TDO, TDO_EN, LATCH_JTAG_IR, TEST_LOGIC_RESET, RUN_TEST_IDLE,
           CAPTURE_DR, SHIFT_DR, UPDATE_DR
  );

  modport slave (
    output TMS, TDI, DR_TDO,
    input  TDO, TDO_EN, LATCH_JTAG_IR, TEST_LOGIC_RESET, RUN_TEST_IDLE,
           CAPTURE_DR, SHIFT_DR, UPDATE_DR
  );
endinterface

// File: rtl/tap_fsm.sv
// 16-state TAP state register advanced by TMS on each TCK rising edge.
// State visible one edge after TMS is sampled; no backpressure (TMS always accepted).
module tap_fsm
  import tap_pkg::*;
(
  input  logic       TCK,
  input  logic       TRST_N,
  input  logic       TMS,
  output tap_state_e state_o
);

  tap_state_e state_q;

  always_ff @(posedge TCK or negedge TRST_N) begin
    if (!TRST_N) begin
      state_q <= S_TLR;
    end else begin
      state_q <= tap_next(state_q, TMS);
    end
  end

  assign state_o = state_q;

endmodule

// File: rtl/tap_controller.sv
// TAP controller: FSM, 4-bit IR capture/shift/update, DR strobes and TDO mux; new IR one edge after UPIR.
// No backpressure. TAP_TDO_NEGEDGE_EN registers TDO/TDO_EN on the TCK falling edge.
module tap_controller
  import tap_pkg::*;
(
  input  logic             TCK,
  input  logic             TRST_N,
  tap_controller_if.master bus
);

  tap_state_e      state;
  logic [IR_W-1:0] ir_sr_q, ir_sr_d;
  logic [IR_W-1:0] ir_latch_q, ir_latch_d;
  logic            tdo_src;
  logic            tdo_en_src;

  tap_fsm u_fsm (
    .TCK     (TCK),
    .TRST_N  (TRST_N),
    .TMS     (bus.TMS),
    .state_o (state)
  );

  // Shift/update decided on the current state, so the TMS=1 exit edge still shifts.
  always_comb begin
    ir_sr_d    = ir_sr_q;
    ir_latch_d = ir_latch_q;
    case (state)
      S_CAPIR: ir_sr_d    = IR_CAPTURE;
      S_SHIR:  ir_sr_d    = {bus.TDI, ir_sr_q[IR_W-1:1]};
      S_UPIR:  ir_latch_d = ir_sr_q;
      S_TLR:   ir_latch_d = IR_RESET;
      default: ;
    endcase
  end

  always_ff @(posedge TCK or negedge TRST_N) begin
    if (!TRST_N) begin
      ir_sr_q    <= IR_CAPTURE;
      ir_latch_q <= IR_RESET;
    end else begin
      ir_sr_q    <= ir_sr_d;
      ir_latch_q <= ir_latch_d;
    end
  end

  assign tdo_src    = (state == S_SHIR) ? ir_sr_q[0] :
                      (state == S_SHDR) ? bus.DR_TDO : 1'b0;
  assign tdo_en_src = (state == S_SHIR) || (state == S_SHDR);

`ifdef TAP_TDO_NEGEDGE_EN
  logic tdo_q;
  logic tdo_en_q;

  always_ff @(negedge TCK or negedge TRST_N) begin
    if (!TRST_N) begin
      tdo_q    <= 1'b0;
      tdo_en_q <= 1'b0;
    end else begin
      tdo_q    <= tdo_src;
      tdo_en_q <= tdo_en_src;
    end
  end

  assign bus.TDO    = tdo_q;
  assign bus.TDO_EN = tdo_en_q;
`else
  assign bus.TDO    = tdo_src;
  assign bus.TDO_EN = tdo_en_src;
`endif

  assign bus.LATCH_JTAG_IR    = ir_latch_q;
  assign bus.TEST_LOGIC_RESET = (state == S_TLR);
  assign bus.RUN_TEST_IDLE    = (state == S_RTI);
  assign bus.CAPTURE_DR       = (state == S_CAPDR);
  assign bus.SHIFT_DR         = (state == S_SHDR);
  assign bus.UPDATE_DR        = (state == S_UPDR);

endmodule

// File: tb/tb_tap_controller.sv
// Directed bench for tap_controller: table-driven TAP model checked every cycle plus literal checks.
module tb_tap_controller;

  logic tck    = 1'b0;
  logic trst_n = 1'b1;

  tap_controller_if bus ();

  tap_controller dut (
    .TCK    (tck),
    .TRST_N (trst_n),
    .bus    (bus)
  );

  always #5 tck = ~tck;

  int vectors     = 0;
  int miscompares = 0;
  bit chk_en      = 1'b0;

  // Model state numbering follows the specification's listing order:
  // 0 TLR 1 RTI 2 SELDR 3 CAPDR 4 SHDR 5 EX1DR 6 PSDR 7 EX2DR 8 UPDR
  // 9 SELIR 10 CAPIR 11 SHIR 12 EX1IR 13 PSIR 14 EX2IR 15 UPIR
  int nxt0 [16] = '{1, 1, 3, 4, 4, 6, 6, 4, 1, 10, 11, 11, 13, 13, 11, 1};
  int nxt1 [16] = '{0, 2, 9, 5, 5, 8, 7, 8, 2, 0, 12, 12, 15, 14, 15, 2};
  int m_st    = 0;
  int m_ir    = 1;
  int m_latch = 7;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors = vectors + 1;
    if (act !== exp) begin
      miscompares = miscompares + 1;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(posedge tck or negedge trst_n) begin
    if (!trst_n) begin
      m_st    <= 0;
      m_ir    <= 1;
      m_latch <= 7;
    end else begin
      if (m_st == 11) m_ir <= (m_ir >> 1) + (bus.TDI ? 8 : 0);
      else if (m_st == 10) m_ir <= 1;
      if (m_st == 15) m_latch <= m_ir;
      else if (m_st == 0) m_latch <= 7;
      m_st <= bus.TMS ? nxt1[m_st] : nxt0[m_st];
    end
  end

  always @(negedge tck) begin
    logic e_tdo;
    #2;
    if (chk_en) begin
      e_tdo = (m_st == 11) ? m_ir[0] : (m_st == 4) ? bus.DR_TDO : 1'b0;
      check("tdo",    32'(bus.TDO),              32'(e_tdo));
      check("tdo_en", 32'(bus.TDO_EN),           32'((m_st == 11) || (m_st == 4)));
      check("latch",  32'(bus.LATCH_JTAG_IR),    32'(m_latch));
      check("tlr",    32'(bus.TEST_LOGIC_RESET), 32'(m_st == 0));
      check("rti",    32'(bus.RUN_TEST_IDLE),    32'(m_st == 1));
      check("capdr",  32'(bus.CAPTURE_DR),       32'(m_st == 3));
      check("shdr",   32'(bus.SHIFT_DR),         32'(m_st == 4));
      check("updr",   32'(bus.UPDATE_DR),        32'(m_st == 8));
    end
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation still running at t=%0t, expected finish", $time);
    $fatal(1, "timeout");
  end

  logic [7:0] dr_pat = 8'b1011_0010;
  logic [2:0] step   = 3'd0;
  logic       obs_tdo;
  logic       obs_tdo_en;
  int         n_cap, n_sh, n_up;

  // Inputs set 2 time units before the falling edge; outputs of that cycle sampled after it.
  task automatic go(input logic tms, input logic tdi);
    bus.TMS    = tms;
    bus.TDI    = tdi;
    bus.DR_TDO = dr_pat[step];
    step       = step + 3'd1;
    @(negedge tck);
    #1;
    obs_tdo    = bus.TDO;
    obs_tdo_en = bus.TDO_EN;
    if (bus.CAPTURE_DR) n_cap = n_cap + 1;
    if (bus.SHIFT_DR)   n_sh  = n_sh + 1;
    if (bus.UPDATE_DR)  n_up  = n_up + 1;
    @(posedge tck);
    #3;
  endtask

  task automatic to_shir();
    go(1'b1, 1'b0);
    go(1'b1, 1'b0);
    go(1'b0, 1'b0);
    go(1'b0, 1'b0);
  endtask

  initial begin
    logic [3:0] tdo_seq;
    logic [3:0] en_seq;
    bus.TMS    = 1'b1;
    bus.TDI    = 1'b0;
    bus.DR_TDO = 1'b0;
    #1 trst_n = 1'b0;
    #1;
    check("rst_tlr",   32'(bus.TEST_LOGIC_RESET), 32'd1);
    check("rst_latch", 32'(bus.LATCH_JTAG_IR),    32'h7);
    check("rst_tdoen", 32'(bus.TDO_EN),           32'd0);
    check("rst_tdo",   32'(bus.TDO),              32'd0);
    check("rst_rti",   32'(bus.RUN_TEST_IDLE),    32'd0);
    chk_en = 1'b1;
    @(posedge tck);
    #3 trst_n = 1'b1;

    go(1'b0, 1'b0);
    check("enter_rti", 32'(bus.RUN_TEST_IDLE), 32'd1);

    // IR load BYPASS: captured 0001 shifts out LSB first while 1111 shifts in
    to_shir();
    go(1'b0, 1'b1); tdo_seq[0] = obs_tdo; en_seq[0] = obs_tdo_en;
    go(1'b0, 1'b1); tdo_seq[1] = obs_tdo; en_seq[1] = obs_tdo_en;
    go(1'b0, 1'b1); tdo_seq[2] = obs_tdo; en_seq[2] = obs_tdo_en;
    go(1'b1, 1'b1); tdo_seq[3] = obs_tdo; en_seq[3] = obs_tdo_en;
    check("ir_tdo_seq", 32'(tdo_seq), 32'h1);
    check("ir_en_seq",  32'(en_seq),  32'hF);
    go(1'b1, 1'b0);
    check("latch_in_upir", 32'(bus.LATCH_JTAG_IR), 32'h7);
    go(1'b0, 1'b0);
    check("latch_bypass", 32'(bus.LATCH_JTAG_IR), 32'hF);

    // DR scan: strobe widths
    n_cap = 0; n_sh = 0; n_up = 0;
    go(1'b1, 1'b0);
    go(1'b0, 1'b0);
    go(1'b0, 1'b0);
    go(1'b0, 1'b0);
    go(1'b0, 1'b0);
    go(1'b0, 1'b0);
    go(1'b1, 1'b0);
    go(1'b1, 1'b0);
    go(1'b0, 1'b0);
    check("capdr_cycles", 32'(n_cap), 32'd1);
    check("shdr_cycles",  32'(n_sh),  32'd4);
    check("updr_cycles",  32'(n_up),  32'd1);
    check("dr_back_rti",  32'(bus.RUN_TEST_IDLE), 32'd1);

    // Five TMS=1 edges from SHDR reach TLR
    go(1'b1, 1'b0);
    go(1'b0, 1'b0);
    go(1'b0, 1'b0);
    check("in_shdr", 32'(bus.SHIFT_DR), 32'd1);
    for (int i = 0; i < 4; i++) go(1'b1, 1'b0);
    check("tlr_after4", 32'(bus.TEST_LOGIC_RESET), 32'd0);
    go(1'b1, 1'b0);
    check("tlr_after5", 32'(bus.TEST_LOGIC_RESET), 32'd1);
    go(1'b1, 1'b0);
    check("tlr_latch", 32'(bus.LATCH_JTAG_IR), 32'h7);
    go(1'b0, 1'b0);

    // Pause mid IR shift: TDI bits 1,0,1,1 -> IR 4'hD
    to_shir();
    go(1'b0, 1'b1);
    go(1'b1, 1'b0);
    go(1'b0, 1'b0);
    go(1'b0, 1'b0);
    go(1'b0, 1'b0);
    go(1'b1, 1'b0);
    go(1'b0, 1'b0);
    go(1'b0, 1'b1);
    go(1'b1, 1'b1);
    check("pause_latch_hold", 32'(bus.LATCH_JTAG_IR), 32'h7);
    go(1'b1, 1'b0);
    go(1'b0, 1'b0);
    check("pause_latch", 32'(bus.LATCH_JTAG_IR), 32'hD);

    // TRST mid-shift discards partial IR
    to_shir();
    go(1'b0, 1'b0);
    go(1'b0, 1'b1);
    #1 trst_n = 1'b0;
    #2;
    check("trst_tlr",   32'(bus.TEST_LOGIC_RESET), 32'd1);
    check("trst_latch", 32'(bus.LATCH_JTAG_IR),    32'h7);
    check("trst_tdoen", 32'(bus.TDO_EN),           32'd0);
    @(posedge tck);
    #3 trst_n = 1'b1;
    go(1'b0, 1'b0);
    go(1'b1, 1'b0);
    check("trst_after_latch", 32'(bus.LATCH_JTAG_IR), 32'h7);
    go(1'b0, 1'b0);

    chk_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
